tft_bus_arbiter: RTL and testbench

Shares the single byte-wide TFT driver interface (tft_dc / tft_data / tft_transmit / tft_busy) between several pixel sources: the init sequencer, the scene exhibitor, and sprite drawers. On each grant it emits the display window setup (CASET, PASET, RAMWR) from the winning requester's rectangle, then hands the bus to that requester in pass-through until it releases. It sits between the drawing blocks and the TFT byte driver.

---
 rtl/tft_bus_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_tft_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter
//   Lets several pixel sources share one byte-wide TFT driver. Requests are
//   granted by fixed priority, where index 0 is the highest. A grant is never
//   preempted, and arbitration only takes place in IDLE.
//   With TFT_ARB_WINDOW_EN defined, each grant first sends the window setup
//   to the driver: CASET x0..x1, PASET y0..y1, then RAMWR. The owner then gets
//   the bus in pass-through.
//   With TFT_ARB_WINDOW_EN undefined, the window ports are ignored. The owner
//   gets pass-through on the cycle after arbitration and sends its own window
//   commands.
//
// Ports
//   clk, rst                synchronous active-high reset
//   req[N_REQ]              request per source, held for the whole transfer
//   req_x0/x1, req_y0/y1    9-bit window bounds per source, slice i = [9i+8:9i]
//   req_dc/data/transmit    per-source byte stream used in pass-through
//   gnt[N_REQ]              one-hot, high only while the owner is in PASS
//   gnt_busy                tft_busy in PASS, 1 otherwise
//   tft_busy                driver busy
//   tft_dc/data/transmit    byte stream to the driver
//   idle                    IDLE with no request pending
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// WIN   | sending the 11-byte window setup for the owner
// PASS  | owner's byte stream drives the TFT driver directly
module tft_bus_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [9*N_REQ-1:0]   req_x0,
    input  logic [9*N_REQ-1:0]   req_x1,
    input  logic [9*N_REQ-1:0]   req_y0,
    input  logic [9*N_REQ-1:0]   req_y1,
    input  logic [N_REQ-1:0]     req_dc,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_transmit,
    output logic [N_REQ-1:0]     gnt,
    output logic                 gnt_busy,
    input  logic                 tft_busy,
    output logic                 tft_dc,
    output logic [7:0]           tft_data,
    output logic                 tft_transmit,
    output logic                 idle
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WIN, ST_PASS} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            tx_q, tx_d;
    logic            dc_q, dc_d;
    logic [7:0]      data_q, data_d;

    logic            any_req;
    logic [OW-1:0]   sel;
    logic            own_req, own_dc, own_tx;
    logic [7:0]      own_data;

`ifdef TFT_ARB_WINDOW_EN
    logic [8:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [3:0]      idx_q, idx_d;
    logic [8:0]      sel_x0, sel_x1, sel_y0, sel_y1;

    function automatic logic [7:0] win_byte(input logic [3:0] idx,
                                            input logic [8:0] x0, input logic [8:0] x1,
                                            input logic [8:0] y0, input logic [8:0] y1);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h2A;
            4'd1:    b = {7'b0, x0[8]};
            4'd2:    b = x0[7:0];
            4'd3:    b = {7'b0, x1[8]};
            4'd4:    b = x1[7:0];
            4'd5:    b = 8'h2B;
            4'd6:    b = {7'b0, y0[8]};
            4'd7:    b = y0[7:0];
            4'd8:    b = {7'b0, y1[8]};
            4'd9:    b = y1[7:0];
            default: b = 8'h2C;
        endcase
        return b;
    endfunction
`else
    logic            unused_win;
    assign unused_win = ^{req_x0, req_x1, req_y0, req_y1};
`endif

    // Lowest set index wins, so scan downward and let lower indices overwrite.
    always_comb begin
        any_req = |req;
        sel     = '0;
`ifdef TFT_ARB_WINDOW_EN
        sel_x0 = '0;
        sel_x1 = '0;
        sel_y0 = '0;
        sel_y1 = '0;
`endif
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = OW'(i);
`ifdef TFT_ARB_WINDOW_EN
                sel_x0 = req_x0[9*i +: 9];
                sel_x1 = req_x1[9*i +: 9];
                sel_y0 = req_y0[9*i +: 9];
                sel_y1 = req_y1[9*i +: 9];
`endif
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_dc   = 1'b0;
        own_tx   = 1'b0;
        own_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req  = req[i];
                own_dc   = req_dc[i];
                own_tx   = req_transmit[i];
                own_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tx_d    = 1'b0;
        dc_d    = dc_q;
        data_d  = data_q;
`ifdef TFT_ARB_WINDOW_EN
        x0_d  = x0_q;
        x1_d  = x1_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        idx_d = idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = sel;
`ifdef TFT_ARB_WINDOW_EN
                    x0_d    = sel_x0;
                    x1_d    = sel_x1;
                    y0_d    = sel_y0;
                    y1_d    = sel_y1;
                    idx_d   = 4'd0;
                    state_d = ST_WIN;
                    // Byte 0 is a constant, so it can go out with the state
                    // change and give one cycle from req to the first strobe.
                    if (!tft_busy && !tx_q) begin
                        tx_d   = 1'b1;
                        data_d = 8'h2A;
                        dc_d   = 1'b0;
                        idx_d  = 4'd1;
                    end
`else
                    state_d = ST_PASS;
`endif
                end
            end
`ifdef TFT_ARB_WINDOW_EN
            ST_WIN: begin
                // idx_q is the next byte to send. The strobe cycle itself is
                // the guard cycle, which hides the driver's late busy rise.
                if (idx_q == 4'd11) begin
                    if (!tx_q) begin
                        state_d = own_req ? ST_PASS : ST_IDLE;
                    end
                end else if (!tft_busy && !tx_q) begin
                    tx_d   = 1'b1;
                    data_d = win_byte(idx_q, x0_q, x1_q, y0_q, y1_q);
                    dc_d   = !(idx_q == 4'd0 || idx_q == 4'd5 || idx_q == 4'd10);
                    idx_d  = idx_q + 4'd1;
                end
            end
`endif
            ST_PASS: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            tx_q    <= 1'b0;
            dc_q    <= 1'b1;
            data_q  <= 8'h00;
`ifdef TFT_ARB_WINDOW_EN
            x0_q  <= '0;
            x1_q  <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tx_q    <= tx_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
`ifdef TFT_ARB_WINDOW_EN
            x0_q  <= x0_d;
            x1_q  <= x1_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            idx_q <= idx_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state_q == ST_PASS) && (owner_q == OW'(i));
        end
    end

    assign gnt_busy     = (state_q == ST_PASS) ? tft_busy : 1'b1;
    assign tft_transmit = (state_q == ST_PASS) ? own_tx   : tx_q;
    assign tft_dc       = (state_q == ST_PASS) ? own_dc   : dc_q;
    assign tft_data     = (state_q == ST_PASS) ? own_data : data_q;
    assign idle         = (state_q == ST_IDLE) && !any_req;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
module tb_tft_bus_arbiter;

    localparam int N = 3;
    typedef logic [10:0][8:0] seq_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [9*N-1:0] req_x0, req_x1, req_y0, req_y1;
    logic [N-1:0]   req_dc;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_transmit;
    logic [N-1:0]   gnt;
    logic           gnt_busy;
    logic           tft_busy;
    logic           tft_dc;
    logic [7:0]     tft_data;
    logic           tft_transmit;
    logic           idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Driver model: busy for busy_len cycles starting the cycle after a strobe.
    int         busy_len = 0;
    int         busy_cnt = 0;
    logic       busy_force = 1'b0;
    logic [8:0] cap_q[$];
    int         viol = 0;

    assign tft_busy = (busy_cnt != 0) || busy_force;

    always #5 clk = ~clk;

    tft_bus_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_dc(req_dc), .req_data(req_data), .req_transmit(req_transmit),
        .gnt(gnt), .gnt_busy(gnt_busy), .tft_busy(tft_busy),
        .tft_dc(tft_dc), .tft_data(tft_data), .tft_transmit(tft_transmit),
        .idle(idle)
    );

    always @(posedge clk) begin
        if (tft_transmit && gnt == '0 && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tft_transmit && gnt == '0) begin
            cap_q.push_back({tft_dc, tft_data});
            if (tft_busy) viol++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic seq_t win_model(input logic [8:0] x0, input logic [8:0] x1,
                                       input logic [8:0] y0, input logic [8:0] y1);
        seq_t s;
        s[0]  = {1'b0, 8'h2A};
        s[1]  = {1'b1, 7'b0, x0[8]};
        s[2]  = {1'b1, x0[7:0]};
        s[3]  = {1'b1, 7'b0, x1[8]};
        s[4]  = {1'b1, x1[7:0]};
        s[5]  = {1'b0, 8'h2B};
        s[6]  = {1'b1, 7'b0, y0[8]};
        s[7]  = {1'b1, y0[7:0]};
        s[8]  = {1'b1, 7'b0, y1[8]};
        s[9]  = {1'b1, y1[7:0]};
        s[10] = {1'b0, 8'h2C};
        return s;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_checks++; if (tft_transmit !== 1'b0) begin n_fail++; $display("FAIL reset_tx got %b want 0", tft_transmit); end
        n_checks++; if (tft_dc !== 1'b1) begin n_fail++; $display("FAIL reset_dc got %b want 1", tft_dc); end
        n_checks++; if (tft_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tft_data); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
        n_checks++; if (gnt_busy !== 1'b1) begin n_fail++; $display("FAIL reset_gnt_busy got %b want 1", gnt_busy); end
        rst = 1'b0;
        step(1);
    endtask

`ifdef TFT_ARB_WINDOW_EN
    task automatic test_window;
        logic [8:0] exp_b [11];
        logic [8:0] got;
        exp_b = '{9'h02A, 9'h100, 9'h110, 9'h101, 9'h14F, 9'h02B,
                  9'h100, 9'h110, 9'h101, 9'h1EF, 9'h02C};
        req_x0[9 +: 9] = 9'd16;  req_x1[9 +: 9] = 9'd335;
        req_y0[9 +: 9] = 9'd16;  req_y1[9 +: 9] = 9'd495;
        cap_q.delete();
        req = 3'b010;
        step(1);
        n_checks++; if (tft_transmit !== 1'b1 || tft_data !== 8'h2A) begin n_fail++; $display("FAIL win_first_strobe got tx=%b data=%h want tx=1 data=2A", tft_transmit, tft_data); end
        step(21);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL win_gnt_c22 got %b want 000", gnt); end
        step(1);
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL win_gnt_c23 got %b want 010", gnt); end
        n_checks++; if (cap_q.size() != 11) begin n_fail++; $display("FAIL win_count got %0d want 11", cap_q.size()); end
        for (int i = 0; i < 11; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 9'h1FF;
            n_checks++;
            if (got !== exp_b[i]) begin n_fail++; $display("FAIL win_byte%0d got dc/data %h want %h", i, got, exp_b[i]); end
        end
    endtask

    task automatic test_pass_mux;
        req_dc = 3'b010; req_data = {8'h00, 8'h3A, 8'h7B}; req_transmit = 3'b011;
        #1;
        n_checks++; if (tft_data !== 8'h3A || tft_dc !== 1'b1 || tft_transmit !== 1'b1) begin n_fail++; $display("FAIL pass_mux got dc=%b data=%h tx=%b want dc=1 data=3A tx=1", tft_dc, tft_data, tft_transmit); end
        step(1);
        req_transmit = 3'b001;
        #1;
        n_checks++; if (tft_transmit !== 1'b0) begin n_fail++; $display("FAIL pass_nonowner_tx got %b want 0", tft_transmit); end
        busy_force = 1'b1;
        #1;
        n_checks++; if (gnt_busy !== 1'b1) begin n_fail++; $display("FAIL pass_gnt_busy_hi got %b want 1", gnt_busy); end
        busy_force = 1'b0;
        #1;
        n_checks++; if (gnt_busy !== 1'b0) begin n_fail++; $display("FAIL pass_gnt_busy_lo got %b want 0", gnt_busy); end
        req_transmit = 3'b000;
        req = 3'b000;
        step(1);
        n_checks++; if (gnt !== 3'b000 || idle !== 1'b1) begin n_fail++; $display("FAIL pass_release got gnt=%b idle=%b want 000/1", gnt, idle); end
        step(1);
    endtask

    task automatic test_priority;
        seq_t       e;
        logic [8:0] got;
        req_x0[0 +: 9] = 9'd5;   req_x1[0 +: 9] = 9'd10;
        req_y0[0 +: 9] = 9'd20;  req_y1[0 +: 9] = 9'd30;
        req_x0[18 +: 9] = 9'd0;  req_x1[18 +: 9] = 9'd319;
        req_y0[18 +: 9] = 9'd0;  req_y1[18 +: 9] = 9'd479;
        req = 3'b101;
        step(23);
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL prio_owner got %b want 001", gnt); end
        req = 3'b100;
        step(1);
        n_checks++; if (gnt !== 3'b000 || idle !== 1'b0 || tft_transmit !== 1'b0) begin n_fail++; $display("FAIL prio_gap got gnt=%b idle=%b tx=%b want 000/0/0", gnt, idle, tft_transmit); end
        cap_q.delete();
        step(23);
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL prio_second got %b want 100", gnt); end
        e = win_model(9'd0, 9'd319, 9'd0, 9'd479);
        for (int i = 0; i < 11; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 9'h1FF;
            n_checks++;
            if (got !== e[i]) begin n_fail++; $display("FAIL prio_byte%0d got %h want %h", i, got, e[i]); end
        end
        req = 3'b000;
        step(2);
    endtask

    task automatic test_busy_drop;
        seq_t       e;
        logic [8:0] got;
        int         gnt_seen;
        gnt_seen = 0;
        busy_len = 5;
        viol     = 0;
        cap_q.delete();
        req = 3'b010;
        step(3);
        req = 3'b000;
        for (int i = 0; i < 120; i++) begin
            step(1);
            if (gnt != '0) gnt_seen++;
        end
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL busy_strobe_while_busy got %0d want 0", viol); end
        n_checks++; if (gnt_seen != 0) begin n_fail++; $display("FAIL busy_drop_gnt got %0d want 0", gnt_seen); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL busy_drop_idle got %b want 1", idle); end
        n_checks++; if (cap_q.size() != 11) begin n_fail++; $display("FAIL busy_count got %0d want 11", cap_q.size()); end
        e = win_model(9'd16, 9'd335, 9'd16, 9'd495);
        for (int i = 0; i < 11; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 9'h1FF;
            n_checks++;
            if (got !== e[i]) begin n_fail++; $display("FAIL busy_byte%0d got %h want %h", i, got, e[i]); end
        end
        busy_len = 0;
        step(2);
    endtask

    task automatic test_reset_mid_win;
        req = 3'b010;
        step(9);
        n_checks++; if (tft_transmit !== 1'b1 || tft_data !== 8'h4F) begin n_fail++; $display("FAIL midrst_byte4 got tx=%b data=%h want 1/4F", tft_transmit, tft_data); end
        rst = 1'b1;
        req = 3'b000;
        step(1);
        n_checks++; if (tft_transmit !== 1'b0 || gnt !== 3'b000 || idle !== 1'b1) begin n_fail++; $display("FAIL midrst_state got tx=%b gnt=%b idle=%b want 0/000/1", tft_transmit, gnt, idle); end
        rst = 1'b0;
        req = 3'b010;
        step(1);
        n_checks++; if (tft_transmit !== 1'b1 || tft_data !== 8'h2A || tft_dc !== 1'b0) begin n_fail++; $display("FAIL midrst_restart got tx=%b dc=%b data=%h want 1/0/2A", tft_transmit, tft_dc, tft_data); end
        step(22);
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL midrst_gnt got %b want 010", gnt); end
        req = 3'b000;
        step(2);
    endtask
`else
    task automatic test_passthrough;
        req_x0 = {9'd1, 9'd2, 9'd3};
        req = 3'b001;
        #1;
        n_checks++; if (gnt !== 3'b000 || tft_transmit !== 1'b0) begin n_fail++; $display("FAIL np_arb_cycle got gnt=%b tx=%b want 000/0", gnt, tft_transmit); end
        step(1);
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL np_gnt got %b want 001", gnt); end
        req_dc = 3'b100; req_data = {8'hAA, 8'h00, 8'h55}; req_transmit = 3'b101;
        #1;
        n_checks++; if (tft_data !== 8'h55 || tft_dc !== 1'b0 || tft_transmit !== 1'b1) begin n_fail++; $display("FAIL np_mux got dc=%b data=%h tx=%b want 0/55/1", tft_dc, tft_data, tft_transmit); end
        req_transmit = 3'b100;
        #1;
        n_checks++; if (tft_transmit !== 1'b0) begin n_fail++; $display("FAIL np_nonowner_tx got %b want 0", tft_transmit); end
        busy_force = 1'b1;
        #1;
        n_checks++; if (gnt_busy !== 1'b1) begin n_fail++; $display("FAIL np_gnt_busy_hi got %b want 1", gnt_busy); end
        busy_force = 1'b0;
        #1;
        n_checks++; if (gnt_busy !== 1'b0) begin n_fail++; $display("FAIL np_gnt_busy_lo got %b want 0", gnt_busy); end
        req_transmit = 3'b000;
        req = 3'b000;
        step(1);
        n_checks++; if (gnt !== 3'b000 || idle !== 1'b1 || tft_transmit !== 1'b0) begin n_fail++; $display("FAIL np_release got gnt=%b idle=%b tx=%b want 000/1/0", gnt, idle, tft_transmit); end
        step(1);
    endtask

    task automatic test_priority;
        req = 3'b101;
        step(1);
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL np_prio_owner got %b want 001", gnt); end
        req = 3'b100;
        step(1);
        n_checks++; if (gnt !== 3'b000 || idle !== 1'b0) begin n_fail++; $display("FAIL np_prio_gap got gnt=%b idle=%b want 000/0", gnt, idle); end
        step(1);
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL np_prio_second got %b want 100", gnt); end
        req = 3'b000;
        step(2);
    endtask

    task automatic test_reset_mid_pass;
        req = 3'b010;
        step(1);
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL np_gnt1 got %b want 010", gnt); end
        rst = 1'b1;
        step(1);
        n_checks++; if (gnt !== 3'b000 || gnt_busy !== 1'b1) begin n_fail++; $display("FAIL np_midrst got gnt=%b gnt_busy=%b want 000/1", gnt, gnt_busy); end
        rst = 1'b0;
        req = 3'b000;
        step(2);
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
        req_dc = '0; req_data = '0; req_transmit = '0;
        test_reset();
`ifdef TFT_ARB_WINDOW_EN
        test_window();
        test_pass_mux();
        test_priority();
        test_busy_drop();
        test_reset_mid_win();
`else
        test_passthrough();
        test_priority();
        test_reset_mid_pass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
